sr_latch_checker: RTL

SR_LATCH_CHECKER -- requirements
Module: sr_latch_checker

---
 rtl/sr_latch_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sr_latch_checker.sv
// Checks a gated SR latch (S/R/E in, Q/QB out) against a cycle-based reference model.
// Earliest error pulse: 2 sync + 1 change-detect + SETTLE_CYC cycles after a pin change; no backpressure.
module sr_latch_checker #(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             R,
  input  logic             E,
  input  logic             Q,
  input  logic             QB,
  input  logic             clr,
  output logic             model_q,
  output logic             model_vld,
  output logic             err_mis,
  output logic             err_cmp,
  output logic             err_fbd,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic             checking
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [4:0]       meta_q, sync_q;
  logic [2:0]       ctl_prev_q;
  logic             model_q_q, model_q_d;
  logic             model_vld_q, model_vld_d;
  logic             err_mis_q, err_mis_d;
  logic             err_cmp_q, err_cmp_d;
  logic             err_fbd_q, err_fbd_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             checking_q, checking_d;

  logic       ss, rs, es, qs, qbs;
  logic [2:0] ctl;
  logic       ctl_chg;
  logic       fbd;
  logic       chk_en;
  logic       err_any;

  assign ss  = sync_q[4];
  assign rs  = sync_q[3];
  assign es  = sync_q[2];
  assign qs  = sync_q[1];
  assign qbs = sync_q[0];

  assign ctl     = {ss, rs, es};
  assign ctl_chg = (ctl != ctl_prev_q);
  assign fbd     = &ctl;

  // Any stimulus change (re)opens the settle window, whatever the current state.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (state_q == IDLE || ctl_chg) begin
      state_d  = SETTLE;
      settle_d = 4'(SETTLE_CYC);
    end else if (state_q == SETTLE) begin
      settle_d = settle_q - 4'd1;
      if (settle_q == 4'd1) begin
        state_d = CHECK;
      end
    end
  end

  always_comb begin
    model_q_d   = model_q_q;
    model_vld_d = model_vld_q;
    if (es && ss && !rs) begin
      model_q_d   = 1'b1;
      model_vld_d = 1'b1;
    end else if (es && !ss && rs) begin
      model_q_d   = 1'b0;
      model_vld_d = 1'b1;
    end else if (es && ss && rs) begin
      model_vld_d = 1'b0;
    end
  end

  // Errors are judged against the state being entered so the first CHECK cycle can already flag.
  // A forbidden input always arrives via a settle window, so it is reported once on CHECK entry.
  always_comb begin
    chk_en     = (state_d == CHECK);
    err_mis_d  = chk_en && model_vld_q && (qs != model_q_q);
    err_cmp_d  = chk_en && (qs == qbs) && !fbd;
    err_fbd_d  = chk_en && fbd && (state_q != CHECK);
    err_any    = err_mis_d || err_cmp_d || err_fbd_d;
    checking_d = chk_en;
  end

  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (err_any) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= '0;
      sync_q       <= '0;
      ctl_prev_q   <= '0;
      state_q      <= IDLE;
      settle_q     <= '0;
      model_q_q    <= 1'b0;
      model_vld_q  <= 1'b0;
      err_mis_q    <= 1'b0;
      err_cmp_q    <= 1'b0;
      err_fbd_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      checking_q   <= 1'b0;
    end else begin
      meta_q       <= {S, R, E, Q, QB};
      sync_q       <= meta_q;
      ctl_prev_q   <= ctl;
      state_q      <= state_d;
      settle_q     <= settle_d;
      model_q_q    <= model_q_d;
      model_vld_q  <= model_vld_d;
      err_mis_q    <= err_mis_d;
      err_cmp_q    <= err_cmp_d;
      err_fbd_q    <= err_fbd_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      checking_q   <= checking_d;
    end
  end

  assign model_q    = model_q_q;
  assign model_vld  = model_vld_q;
  assign err_mis    = err_mis_q;
  assign err_cmp    = err_cmp_q;
  assign err_fbd    = err_fbd_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
  assign checking   = checking_q;

endmodule
